// File: rtl/sp_ram_req_pkg.sv
// Shared types and constants for the single-port RAM request controller.
package sp_ram_req_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic [0:0] {
    INIT,
    RUN
  } ctrl_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
  } resp_t;

endpackage

// File: rtl/sp_ram_req_ctrl_if.sv
// Core-side req/gnt request and rvalid/rready response bundle of sp_ram_req_ctrl.
interface sp_ram_req_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                    req;
  logic                    gnt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (
    output req, addr, we, be, wdata, rready,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata, rready,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/sp_ram_resp_fifo.sv
// Circular response buffer; any DEPTH >= 2, head presented from registered storage.
module sp_ram_resp_fifo #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic [CntW-1:0]  count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             full, push_eff, pop_eff;

  assign full     = (count_q == CntW'(DEPTH));
  assign pop_eff  = pop_i & (count_q != '0);
  // A pop in the same cycle frees the slot, so push at full is fine then.
  assign push_eff = push_i & (~full | pop_eff);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CntW'(push_eff) - CntW'(pop_eff);
    if (push_eff) begin
      wptr_d = (wptr_q == PtrW'(DEPTH - 1)) ? '0 : wptr_q + PtrW'(1);
    end
    if (pop_eff) begin
      rptr_d = (rptr_q == PtrW'(DEPTH - 1)) ? '0 : rptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (push_eff) begin
        mem_q[wptr_q] <= wdata_i;
      end
    end
  end

  assign valid_o = (count_q != '0);
  assign rdata_o = valid_o ? mem_q[rptr_q] : '0;
  assign count_o = count_q;

`ifndef SYNTHESIS
  push_not_full_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full && !pop_i));
`endif

endmodule

// File: rtl/sp_ram_req_ctrl.sv
// Core req/gnt to single-port RAM access controller with buffered in-order responses.
// Optional power-up RAM fill is enabled by defining MEM_INIT_EN.
module sp_ram_req_ctrl
  import sp_ram_req_pkg::*;
#(
  parameter int unsigned RAM_SIZE   = 32768,
  parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RESP_DEPTH = 3,
  parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rstn_i,
  sp_ram_req_ctrl_if.slave      core,
  output logic                  init_done_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [BE_W-1:0]       ram_be_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  localparam int unsigned CntW = $clog2(RESP_DEPTH + 1);
  localparam int unsigned OccW = CntW + 1;

  ctrl_state_e           state;
  logic                  init_active;
  logic [ADDR_WIDTH-1:0] init_addr;

`ifdef MEM_INIT_EN
  ctrl_state_e             state_q, state_d;
  logic [ADDR_WIDTH-3:0]   init_idx_q, init_idx_d;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    if (state_q == INIT) begin
      init_idx_d = init_idx_q + (ADDR_WIDTH - 2)'(1);
      if (init_idx_q == '1) begin
        state_d = RUN;
      end
    end
  end

  assign state       = state_q;
  // Gate with reset so the RAM sees no enable while the controller is held in reset.
  assign init_active = rstn_i & (state_q == INIT);
  assign init_addr   = {init_idx_q, 2'b00};
`else
  assign state       = RUN;
  assign init_active = 1'b0;
  assign init_addr   = '0;
`endif

  logic            pending_q;
  logic            we_q;
  logic [CntW-1:0] count;
  logic [OccW-1:0] occupancy;
  logic            gnt;
  logic            pop;
  resp_t           push_resp;
  resp_t           head_resp;
  logic            unused_addr;

  assign unused_addr = ^core.addr[1:0];

  // Reserve a FIFO slot for the access whose RAM data lands next cycle.
  assign occupancy = OccW'(count) + OccW'(pending_q);
  assign gnt       = core.req & (state == RUN) & (occupancy < OccW'(RESP_DEPTH));
  assign core.gnt  = gnt;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      pending_q <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      pending_q <= gnt;
      we_q      <= gnt & core.we;
    end
  end

  assign push_resp.data = we_q ? '0 : ram_rdata_i;
  assign pop            = core.rvalid & core.rready;

  sp_ram_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH ($bits(resp_t))
  ) u_resp_fifo (
    .clk_i   (clk),
    .rst_ni  (rstn_i),
    .push_i  (pending_q),
    .wdata_i (push_resp),
    .pop_i   (pop),
    .rdata_o (head_resp),
    .valid_o (core.rvalid),
    .count_o (count)
  );

  assign core.rdata  = head_resp.data;
  assign init_done_o = (state == RUN);

  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (init_active) begin
      ram_en_o    = 1'b1;
      ram_we_o    = 1'b1;
      ram_be_o    = '1;
      ram_addr_o  = init_addr;
      ram_wdata_o = INIT_VALUE;
    end else if (gnt) begin
      ram_en_o    = 1'b1;
      ram_we_o    = core.we;
      ram_be_o    = core.be;
      ram_addr_o  = {core.addr[ADDR_WIDTH-1:2], 2'b00};
      ram_wdata_o = core.wdata;
    end
  end

endmodule
